// File: rtl/proj_lane_ctrl_if.sv
// Report stream between the lane sequencer and the status/debug consumer.
// Each transfer carries one {lane index[7:0], error snapshot[EW-1:0]} record.
interface proj_lane_ctrl_if #(
    parameter int EW = 8
);
    logic [8+EW-1:0] rptdata;
    logic            rptvld;
    logic            rptrdy;

    modport master (output rptdata, output rptvld, input rptrdy);
    modport slave  (input rptdata, input rptvld, output rptrdy);
endinterface

// File: rtl/proj_lane_ctrl.sv
// Test sequencer for N generator->afifo->checker lanes.
// The sequencer runs all lanes for RUNCYC cycles, drains them for DRNCYC cycles,
// snapshots each lane's error counter, reports one record per lane and flags pass/fail.
// Optional feature macro: PROJ_LANE_CTRL_SKIPCLEAN_EN -- report only lanes that
// flagged an error, searching one lane per cycle.

// Per-lane sticky error flag and error-count snapshot.
module proj_lane_ctrl_lane #(
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          upd,
    input  logic          cap,
    input  logic          flg,
    input  logic [EW-1:0] cnt,
    output logic          stk_nxt,
    output logic [EW-1:0] snap_nxt
);
    logic          stk_q;
    logic [EW-1:0] snap_q;

    // Clear wins over set so every test starts clean; next values are exported
    // so the sequencer can decide on the same edge the last flag arrives.
    always_comb begin
        stk_nxt  = clr ? 1'b0 : (stk_q | (upd & flg));
        snap_nxt = cap ? cnt : snap_q;
    end

    // Lane state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stk_q  <= 1'b0;
            snap_q <= '0;
        end else begin
            stk_q  <= stk_nxt;
            snap_q <= snap_nxt;
        end
    end
endmodule

module proj_lane_ctrl #(
    parameter int          N      = 4,
    parameter int          EW     = 8,
    parameter int          TW     = 16,
    parameter int          RUNCYC = 1000,
    parameter int          DRNCYC = 64,
    parameter logic [63:0] ID     = "LANECTRL"
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [N*EW-1:0]     errcntr,
    input  logic [N-1:0]        errflg,
    output logic [N-1:0]        run,
    output logic                busy,
    output logic                done,
    output logic                pass,
    proj_lane_ctrl_if.master    rpt
);
    localparam int              PW     = $clog2(N + 1);
    localparam logic [TW-1:0]   RUN_LD = TW'(RUNCYC - 1);
    localparam logic [TW-1:0]   DRN_LD = TW'(DRNCYC - 1);
    localparam logic [PW-1:0]   LAST   = PW'(N - 1);

    // Elaboration-time parameter sanity.
    if (N < 1 || N > 255) begin : g_chk_n
        $error("proj_lane_ctrl: N must be 1..255");
    end
    if (RUNCYC < 1 || RUNCYC > (2**TW) - 1) begin : g_chk_run
        $error("proj_lane_ctrl: RUNCYC out of range");
    end
    if (DRNCYC < 1 || DRNCYC > (2**TW) - 1) begin : g_chk_drn
        $error("proj_lane_ctrl: DRNCYC out of range");
    end
    if (ID == '0) begin : g_chk_id
        $error("proj_lane_ctrl: ID must be non-empty");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_REPORT,
        S_DONE
    } state_t;

    state_t              state, state_n;
    logic [TW-1:0]       tmr, tmr_n;
    logic [PW-1:0]       ptr, ptr_n;
    logic                clr, upd, cap, adv;
    logic [N-1:0]        stk_nxt;
    logic [N-1:0][EW-1:0] snap_nxt;
    logic [EW-1:0]       rsel;
`ifdef PROJ_LANE_CTRL_SKIPCLEAN_EN
    logic                fsel;
`endif

    logic [N-1:0]        run_q;
    logic                busy_q, done_q, pass_q, rptvld_q;
    logic [8+EW-1:0]     rptdata_q;
    logic [N-1:0]        run_n;
    logic                busy_n, done_n, pass_n, rptvld_n;
    logic [8+EW-1:0]     rptdata_n;

    for (genvar i = 0; i < N; i++) begin : g_lane
        proj_lane_ctrl_lane #(.EW(EW)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr),
            .upd      (upd),
            .cap      (cap),
            .flg      (errflg[i]),
            .cnt      (errcntr[i*EW +: EW]),
            .stk_nxt  (stk_nxt[i]),
            .snap_nxt (snap_nxt[i])
        );
    end

    // Next-state, timer, pointer and lane-control decode.
    always_comb begin
        state_n = state;
        tmr_n   = tmr;
        ptr_n   = ptr;
        adv     = 1'b0;
        clr     = ((state == S_IDLE) || (state == S_DONE)) && start;
        upd     = (state == S_RUN) || (state == S_DRAIN);
        cap     = (state == S_DRAIN) && (tmr == '0);
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n = S_RUN;
                    tmr_n   = RUN_LD;
                end
            end
            S_RUN: begin
                if ((tmr == '0) || abort) begin
                    state_n = S_DRAIN;
                    tmr_n   = DRN_LD;
                end else begin
                    tmr_n = tmr - TW'(1);
                end
            end
            S_DRAIN: begin
                if (tmr == '0) begin
                    ptr_n = '0;
`ifdef PROJ_LANE_CTRL_SKIPCLEAN_EN
                    state_n = (|stk_nxt) ? S_REPORT : S_DONE;
`else
                    state_n = S_REPORT;
`endif
                end else begin
                    tmr_n = tmr - TW'(1);
                end
            end
            S_REPORT: begin
`ifdef PROJ_LANE_CTRL_SKIPCLEAN_EN
                // A clean lane is passed over without a record.
                adv = rptvld_q ? rpt.rptrdy : 1'b1;
`else
                adv = rpt.rptrdy;
`endif
                if (adv) begin
                    if (ptr == LAST) state_n = S_DONE;
                    else             ptr_n   = ptr + PW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Registered-output decode from the next state, so outputs track state exactly.
    always_comb begin
        rsel = '0;
`ifdef PROJ_LANE_CTRL_SKIPCLEAN_EN
        fsel = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            if (ptr_n == PW'(i)) begin
                rsel = snap_nxt[i];
`ifdef PROJ_LANE_CTRL_SKIPCLEAN_EN
                fsel = stk_nxt[i];
`endif
            end
        end
        run_n  = {N{state_n == S_RUN}};
        busy_n = (state_n == S_RUN) || (state_n == S_DRAIN) || (state_n == S_REPORT);
        done_n = (state_n == S_DONE);
        pass_n = (state_n == S_DONE) && ~(|stk_nxt);
`ifdef PROJ_LANE_CTRL_SKIPCLEAN_EN
        rptvld_n = (state_n == S_REPORT) && fsel;
`else
        rptvld_n = (state_n == S_REPORT);
`endif
        rptdata_n = (state_n == S_REPORT) ? {8'(ptr_n), rsel} : '0;
    end

    // FSM and datapath registers; reset drops run and rptvld immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            tmr       <= '0;
            ptr       <= '0;
            run_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            rptvld_q  <= 1'b0;
            rptdata_q <= '0;
        end else begin
            state     <= state_n;
            tmr       <= tmr_n;
            ptr       <= ptr_n;
            run_q     <= run_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            pass_q    <= pass_n;
            rptvld_q  <= rptvld_n;
            rptdata_q <= rptdata_n;
        end
    end

    assign run         = run_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign rpt.rptvld  = rptvld_q;
    assign rpt.rptdata = rptdata_q;
endmodule

// File: tb/tb_proj_lane_ctrl.sv
// Scoreboard bench for proj_lane_ctrl: stimulus pushes expected report records,
// an independent monitor pops and compares on every handshake.
module tb_proj_lane_ctrl;
    localparam int N = 4, EW = 8, TW = 16, RUNCYC = 10, DRNCYC = 4;
`ifdef PROJ_LANE_CTRL_SKIPCLEAN_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic            clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
    logic [N*EW-1:0] errcntr = '0;
    logic [N-1:0]    errflg = '0;
    logic [N-1:0]    run;
    logic            busy, done, pass;

    proj_lane_ctrl_if #(.EW(EW)) rpt_if ();

    proj_lane_ctrl #(.N(N), .EW(EW), .TW(TW), .RUNCYC(RUNCYC), .DRNCYC(DRNCYC)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .errcntr (errcntr),
        .errflg  (errflg),
        .run     (run),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .rpt     (rpt_if)
    );

    always #5 clk = ~clk;

    int              total = 0, passed = 0;
    logic [8+EW-1:0] exp_q[$];
    logic [8+EW-1:0] exp_e, data_prev;
    bit              hold_prev = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    endtask

    // Monitor: compare every transferred record, and check records hold under backpressure.
    always @(negedge clk) begin
        if (!rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_vld", 64'(rpt_if.rptvld), 64'(1));
                chk("hold_data", 64'(rpt_if.rptdata), 64'(data_prev));
            end
            if (rpt_if.rptvld && rpt_if.rptrdy) begin
                if (exp_q.size() == 0) begin
                    chk("extra_record", 64'(rpt_if.rptvld), 64'(0));
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("record", 64'(rpt_if.rptdata), 64'(exp_e));
                end
            end
            hold_prev = rpt_if.rptvld && !rpt_if.rptrdy;
            data_prev = rpt_if.rptdata;
        end
    end

    // One test: mode selects error pattern (0 none, 1 lane2 cnt 5 from cycle 3,
    // 2 random, 3 all lanes, 4 lane1 only). Cycle t=1 is the first run cycle.
    task automatic do_test(input int mode, input int abort_at, input int bp,
                           input bit rnd_rdy, input bit start_drain, input int rst_at);
        logic [N-1:0]         stk;
        logic [N-1:0][EW-1:0] snap;
        int L, W, run_cnt, first_evt, exp_first;
        bit fin;
        L = (abort_at > 0) ? abort_at : RUNCYC;
        W = L + DRNCYC;
        stk = '0; snap = '0; run_cnt = 0; first_evt = 0; fin = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        abort = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        errflg = '0; errcntr = '0;
        rpt_if.rptrdy = 1'b0;
        for (int t = 1; t <= 400; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (run == {N{1'b1}}) run_cnt++;
            else if (run != '0) chk("run_pattern", 64'(run), 64'({N{1'b1}}));
            if (first_evt == 0 && (rpt_if.rptvld || done)) first_evt = t;
            if (t == rst_at) begin
                rst = 1'b0; #1;
                chk("rst_run", 64'(run), 64'(0));
                chk("rst_vld", 64'(rpt_if.rptvld), 64'(0));
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_done", 64'(done), 64'(0));
                chk("rst_pass", 64'(pass), 64'(0));
                exp_q.delete();
                abort = 1'b0; errflg = '0;
                repeat (2) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk); #1;
                chk("post_rst_busy", 64'(busy), 64'(0));
                chk("post_rst_done", 64'(done), 64'(0));
                chk("post_rst_run", 64'(run), 64'(0));
                return;
            end
            if (done) begin
                fin = 1'b1;
                break;
            end
            abort = (t == abort_at);
            if (mode == 2 && t > L) abort = 1'($urandom_range(0, 1));
            if (start_drain && t == L + 2) start = 1'b1;
            case (mode)
                0: begin errflg = '0; errcntr = '0; end
                1: begin
                    errflg = (t >= 3) ? 4'b0100 : 4'b0000;
                    errcntr = (t >= 3) ? 32'h0005_0000 : 32'h0;
                end
                2: begin
                    for (int i = 0; i < N; i++)
                        errflg[i] = (t <= W) ? ($urandom_range(0, 15) == 0) : 1'($urandom_range(0, 1));
                    errcntr = (N*EW)'($urandom);
                end
                3: begin errflg = '1; errcntr = (N*EW)'($urandom); end
                default: begin errflg = 4'b0010; errcntr = (N*EW)'($urandom); end
            endcase
            if (t <= W) stk = stk | errflg;
            if (t == W) begin
                for (int i = 0; i < N; i++) begin
                    snap[i] = errcntr[i*EW +: EW];
                    if (!SKIP || stk[i]) exp_q.push_back({8'(i), snap[i]});
                end
            end
            rpt_if.rptrdy = (t > W + bp) ? (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
        end
        abort = 1'b0;
        chk("done_reached", 64'(fin), 64'(1));
        chk("run_cycles", 64'(run_cnt), 64'(L));
        exp_first = W + 1;
        if (SKIP && stk != '0) begin
            for (int i = N - 1; i >= 0; i--) if (stk[i]) exp_first = W + 1 + i;
        end
        chk("first_evt_cycle", 64'(first_evt), 64'(exp_first));
        chk("pass", 64'(pass), 64'(stk == '0));
        chk("busy_in_done", 64'(busy), 64'(0));
        chk("vld_in_done", 64'(rpt_if.rptvld), 64'(0));
        chk("records_left", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        rpt_if.rptrdy = 1'b0;
        #1;
        chk("reset_run", 64'(run), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_pass", 64'(pass), 64'(0));
        chk("reset_vld", 64'(rpt_if.rptvld), 64'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        do_test(0, 0, 0, 1'b0, 1'b0, 0);                      // clean run
        do_test(1, 0, 0, 1'b0, 1'b0, 0);                      // lane 2 error
        do_test(3, 0, 7, 1'b0, 1'b0, 0);                      // backpressure
        do_test(0, 4, 0, 1'b0, 1'b1, 0);                      // abort + start in drain
        do_test(3, 0, 0, 1'b0, 1'b0, RUNCYC + DRNCYC + 3);    // reset mid-report
        do_test(0, 0, 0, 1'b0, 1'b0, 0);                      // clean rerun
        do_test(4, 0, 0, 1'b0, 1'b0, 0);                      // only lane 1 flagged
        for (int k = 0; k < 12; k++)
            do_test(2, ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, RUNCYC)) : 0,
                    int'($urandom_range(0, 5)), 1'b1, 1'($urandom_range(0, 1)), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
